// File: rtl/print_arb_pkg.sv
// print_arb_pkg -- shared definitions for the print arbiter.
//   arb_state_e    : FSM state encoding (IDLE=0, XFER=1, GAP=2)
//   DEF_*          : default parameter values of print_arbiter
//   STALL_W/GAP_W  : widths of the stall and gap counters
package print_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   localparam int DEF_NREQ       = 3;
   localparam int DEF_GAP_CYCLES = 16;
   localparam int DEF_TIMEOUT    = 4096;

   localparam int STALL_W = 20;
   localparam int GAP_W   = 16;

endpackage

// File: rtl/print_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin one-hot picker.
//   i_req [NREQ] : request vector
//   i_ptr        : index that has top priority this round
//   o_gnt [NREQ] : one-hot grant, first request at or after i_ptr (mod NREQ);
//                  all zero when nothing is requesting
module rr_pick
   import print_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   output logic [NREQ-1:0]         o_gnt
);

   localparam int PW = $clog2(NREQ);

   logic          w_found;
   logic [PW-1:0] w_idx;

   // Walk the sources starting at the pointer; first hit wins.
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = PW'((int'(i_ptr) + k) % NREQ);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/print_arbiter.sv
// print_arbiter -- shares one UART transmitter between NREQ byte sources.
// A source owns the UART for a whole message (until src_last), then the
// block idles GAP_CYCLES cycles before arbitrating again (round robin).
// A granted source that stops supplying bytes for TIMEOUT cycles is dropped.
//   i_clk, i_reset             : clock, synchronous active-high reset
//   i_src_valid/data/last      : per-source byte stream (source i at data[8i+7:8i])
//   o_src_ready                : per-source byte accept
//   o_grant                    : one-hot current owner (zero when none)
//   o_tx_data/o_tx_valid       : byte to UART, held stable until i_tx_ready
//   i_tx_ready                 : UART accepts the byte
//   o_busy                     : high in XFER and GAP
//   o_timeout_pulse            : one-cycle pulse when a source is dropped
module print_arbiter
   import print_arb_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NREQ-1:0]   i_src_valid,
   input  logic [8*NREQ-1:0] i_src_data,
   input  logic [NREQ-1:0]   i_src_last,
   output logic [NREQ-1:0]   o_src_ready,
   output logic [NREQ-1:0]   o_grant,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_timeout_pulse
);

   localparam int PW = $clog2(NREQ);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

   arb_state_e         r_state;
   logic [PW-1:0]      r_rr_ptr;
   logic [PW-1:0]      r_gidx;
   logic [NREQ-1:0]    r_grant;
   logic [7:0]         r_tx_data;
   logic               r_tx_valid;
   logic [STALL_W-1:0] r_stall;
   logic [GAP_W-1:0]   r_gap;
   logic               r_timeout_pulse;

   logic [NREQ-1:0][7:0] w_bytes;
   logic [NREQ-1:0]      w_pick;
   logic [PW-1:0]        w_pick_idx;
   logic [PW-1:0]        w_next_ptr;
   logic                 w_xfer;
   logic                 w_g_valid;
   logic                 w_can_take;
   logic                 w_accept;
   logic                 w_stall;
   logic                 w_timeout;
   logic                 w_end_msg;

   assign w_bytes = i_src_data;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .i_req (i_src_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_pick[i]) w_pick_idx = PW'(i);
   end

   assign w_xfer     = (r_state == XFER);
   assign w_g_valid  = i_src_valid[r_gidx];
   // Output register can take a byte when empty or draining this cycle.
   assign w_can_take = ~r_tx_valid | i_tx_ready;
   assign w_accept   = w_xfer & w_g_valid & w_can_take;
   // Only a silent source counts as a stall; UART back-pressure does not.
   assign w_stall    = w_xfer & ~w_g_valid;
   assign w_timeout  = w_stall & (r_stall == STALL_LAST);
   assign w_end_msg  = (w_accept & i_src_last[r_gidx]) | w_timeout;
   assign w_next_ptr = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;

   assign o_src_ready     = (w_xfer && w_can_take) ? r_grant : '0;
   assign o_grant         = r_grant;
   assign o_tx_data       = r_tx_data;
   assign o_tx_valid      = r_tx_valid;
   assign o_busy          = (r_state != IDLE);
   assign o_timeout_pulse = r_timeout_pulse;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= IDLE;
         r_rr_ptr        <= '0;
         r_gidx          <= '0;
         r_grant         <= '0;
         r_tx_data       <= '0;
         r_tx_valid      <= 1'b0;
         r_stall         <= '0;
         r_gap           <= '0;
         r_timeout_pulse <= 1'b0;
      end else begin
         r_timeout_pulse <= w_timeout;

         // One-entry output register drains regardless of FSM state.
         if (w_accept) begin
            r_tx_data  <= w_bytes[r_gidx];
            r_tx_valid <= 1'b1;
         end else if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (|i_src_valid) begin
                  r_grant <= w_pick;
                  r_gidx  <= w_pick_idx;
                  r_stall <= '0;
                  r_state <= XFER;
               end
            end
            XFER: begin
               if (w_accept)
                  r_stall <= '0;
               else if (w_stall && r_stall != STALL_LAST)
                  r_stall <= r_stall + 1'b1;
               if (w_end_msg) begin
                  r_grant  <= '0;
                  r_rr_ptr <= w_next_ptr;
                  r_gap    <= '0;
                  r_state  <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               // Hold in GAP until the last byte has left the output register.
               if (r_gap == GAP_LAST && !r_tx_valid)
                  r_state <= IDLE;
               else if (r_gap != GAP_LAST)
                  r_gap <= r_gap + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_print_arbiter.sv
// tb_print_arbiter -- directed checks of print_arbiter.
//   dut  : NREQ=3, GAP_CYCLES=16, TIMEOUT=64
//   dut0 : NREQ=3, GAP_CYCLES=0,  TIMEOUT=64 (back-to-back messages)
module tb_print_arbiter;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   a_valid, a_last, a_ready, a_grant;
   logic [8*N-1:0] a_data;
   logic [7:0]     a_txd;
   logic           a_txv, a_txr, a_busy, a_to;

   logic [N-1:0]   b_valid, b_last, b_ready, b_grant;
   logic [8*N-1:0] b_data;
   logic [7:0]     b_txd;
   logic           b_txv, b_txr, b_busy, b_to;

   print_arbiter #(.NREQ(N), .GAP_CYCLES(16), .TIMEOUT(64)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_src_valid(a_valid), .i_src_data(a_data), .i_src_last(a_last),
      .o_src_ready(a_ready), .o_grant(a_grant),
      .o_tx_data(a_txd), .o_tx_valid(a_txv), .i_tx_ready(a_txr),
      .o_busy(a_busy), .o_timeout_pulse(a_to)
   );

   print_arbiter #(.NREQ(N), .GAP_CYCLES(0), .TIMEOUT(64)) dut0 (
      .i_clk(clk), .i_reset(rst),
      .i_src_valid(b_valid), .i_src_data(b_data), .i_src_last(b_last),
      .o_src_ready(b_ready), .o_grant(b_grant),
      .o_tx_data(b_txd), .o_tx_valid(b_txv), .i_tx_ready(b_txr),
      .o_busy(b_busy), .o_timeout_pulse(b_to)
   );

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
      a_valid[s]       = v;
      a_data[8*s +: 8] = d;
      a_last[s]        = l;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      a_valid = '0; a_last = '0; a_data = '0; a_txr = 1'b1;
      b_valid = '0; b_last = '0; b_data = '0; b_txr = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] msg [4];
      int left_msgs [N];
      int bidx [N];
      int order [$];
      int exp_order [4];
      logic [N-1:0] prev_g, acc, accb;
      logic [7:0] accd;
      int gi, w, hs, t0, t1;
      bit done;

      msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0D; msg[3] = 8'h0A;
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;

      // ---- reset state, with every source requesting ----
      a_valid = '1; a_last = '0; a_data = '0; a_txr = 1'b1;
      b_valid = '0; b_last = '0; b_data = '0; b_txr = 1'b1;
      rst = 1'b1;
      tick; tick;
      chk("rst_grant", a_grant, 0);
      chk("rst_ready", a_ready, 0);
      chk("rst_txv",   a_txv, 0);
      chk("rst_txd",   a_txd, 0);
      chk("rst_busy",  a_busy, 0);
      chk("rst_to",    a_to, 0);
      chk("rst_ptr",   dut.r_rr_ptr, 0);
      chk("rst_state", dut.r_state, 0);

      // ---- "Hi\r\n" from source 1 ----
      a_valid = '0;
      rst = 1'b0;
      set_src(1, 1'b1, msg[0], 1'b0);
      tick;
      chk("hi_grant0", a_grant, 3'b010);
      for (int i = 0; i < 4; i++) begin
         set_src(1, 1'b1, msg[i], (i == 3));
         #1;
         chk("hi_ready", a_ready, 3'b010);
         tick;
         chk("hi_txv", a_txv, 1);
         chk("hi_txd", a_txd, msg[i]);
         chk("hi_grant", a_grant, (i < 3) ? 3'b010 : 3'b000);
      end
      set_src(1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 16; k++) begin
         chk("hi_gap_busy", a_busy, 1);
         tick;
      end
      chk("hi_gap_end", a_busy, 0);

      // ---- all sources requesting from reset ----
      do_reset;
      left_msgs[0] = 2; left_msgs[1] = 1; left_msgs[2] = 1;
      for (int s = 0; s < N; s++) bidx[s] = 0;
      prev_g = '0;
      done = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         for (int s = 0; s < N; s++)
            set_src(s, left_msgs[s] > 0, 8'(s*16 + bidx[s]), bidx[s] == 1);
         #1;
         acc  = a_ready & a_valid;
         accd = 8'h00;
         for (int s = 0; s < N; s++)
            if (acc[s]) accd = 8'(s*16 + bidx[s]);
         chk("rr_onehot", $onehot0(a_grant), 1);
         tick;
         if (acc != '0) chk("rr_txd", a_txd, accd);
         for (int s = 0; s < N; s++)
            if (acc[s]) begin
               if (bidx[s] == 1) begin
                  bidx[s] = 0;
                  left_msgs[s]--;
               end else begin
                  bidx[s]++;
               end
            end
         if (a_grant != '0 && a_grant != prev_g) begin
            gi = 0;
            for (int s = 0; s < N; s++) if (a_grant[s]) gi = s;
            order.push_back(gi);
         end
         prev_g = a_grant;
         done = (left_msgs[0] == 0 && left_msgs[1] == 0 && left_msgs[2] == 0 && !a_busy);
      end
      chk("rr_done", done, 1);
      chk("rr_count", order.size(), 4);
      for (int i = 0; i < 4; i++)
         if (order.size() > i) chk("rr_order", order[i], exp_order[i]);

      // ---- long tx back-pressure, then GAP held by pending byte ----
      do_reset;
      set_src(0, 1'b1, 8'hA0, 1'b0);
      tick;
      tick;
      chk("bp_txd0", a_txd, 8'hA0);
      set_src(0, 1'b1, 8'hA1, 1'b0);
      a_txr = 1'b0;
      #1;
      chk("bp_ready0", a_ready, 0);
      for (int k = 0; k < 100; k++) begin
         tick;
         chk("bp_hold_txd", a_txd, 8'hA0);
         chk("bp_hold_txv", a_txv, 1);
         chk("bp_no_to", a_to, 0);
      end
      a_txr = 1'b1;
      #1;
      chk("bp_ready1", a_ready, 3'b001);
      tick;
      chk("bp_txd1", a_txd, 8'hA1);
      set_src(0, 1'b1, 8'hA2, 1'b1);
      tick;
      chk("bp_txd2", a_txd, 8'hA2);
      chk("bp_grant", a_grant, 0);
      a_txr = 1'b0;
      set_src(0, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 30; k++) begin
         tick;
         chk("gap_hold_busy", a_busy, 1);
      end
      a_txr = 1'b1;
      tick;
      chk("gap_drain_busy", a_busy, 1);
      chk("gap_drain_txv", a_txv, 0);
      tick;
      chk("gap_exit", a_busy, 0);

      // ---- stalled source is dropped after 64 silent cycles ----
      do_reset;
      set_src(0, 1'b1, 8'hB0, 1'b0);
      tick;
      tick;
      chk("to_txd", a_txd, 8'hB0);
      set_src(0, 1'b0, 8'h00, 1'b0);
      set_src(1, 1'b1, 8'hC1, 1'b1);
      for (int k = 0; k < 63; k++) begin
         tick;
         chk("to_early", a_to, 0);
         chk("to_grant", a_grant, 3'b001);
         chk("to_other_rdy", a_ready & 3'b110, 0);
      end
      tick;
      chk("to_pulse", a_to, 1);
      chk("to_grant_clr", a_grant, 0);
      chk("to_busy", a_busy, 1);
      tick;
      chk("to_pulse_end", a_to, 0);
      w = 0;
      while (a_grant == '0 && w < 40) begin
         tick;
         w++;
      end
      chk("to_next_grant", a_grant, 3'b010);
      chk("to_next_wait", w, 16);
      tick;
      chk("to_next_txd", a_txd, 8'hC1);
      set_src(1, 1'b0, 8'h00, 1'b0);

      // ---- reset mid-message with a held byte ----
      do_reset;
      set_src(0, 1'b1, 8'h50, 1'b0);
      tick;
      tick;
      set_src(0, 1'b1, 8'h51, 1'b0);
      tick;
      chk("mr_txd1", a_txd, 8'h51);
      a_txr = 1'b0;
      set_src(0, 1'b1, 8'h52, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk("mr_hold", a_txd, 8'h51);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      a_valid = '0;
      a_txr = 1'b1;
      chk("mr_txv", a_txv, 0);
      chk("mr_grant", a_grant, 0);
      chk("mr_ptr", dut.r_rr_ptr, 0);
      chk("mr_busy", a_busy, 0);
      hs = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (a_txv && a_txr) hs++;
         tick;
      end
      chk("mr_no_hs", hs, 0);

      // ---- zero gap: back-to-back sources 0 and 1 ----
      do_reset;
      b_valid = 3'b011;
      b_last  = 3'b011;
      b_data  = {8'h00, 8'hE0, 8'hD0};
      t0 = -100;
      t1 = -100;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         accb = b_ready & b_valid;
         tick;
         if (accb[0]) begin
            t0 = cyc;
            b_valid[0] = 1'b0;
            chk("g0_txd0", b_txd, 8'hD0);
         end
         if (accb[1]) begin
            t1 = cyc;
            b_valid[1] = 1'b0;
            chk("g0_txd1", b_txd, 8'hE0);
         end
      end
      chk("g0_first", t0, 1);
      chk("g0_spacing", t1 - t0, 2);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/print_arbiter.md
PRINT_ARBITER -- requirements
Module: print_arbiter

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of message sources (2..8).
REQ-002 Parameter GAP_CYCLES, default 16, SHALL set the idle cycles inserted after each message (0..65535).
REQ-003 Parameter TIMEOUT, default 4096, SHALL set the stall cycles before a granted source is dropped (2..2^20).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 src_valid  in  NREQ  per-source byte valid.
REQ-007 src_data  in  8*NREQ  per-source byte; source i occupies bits [8i+7:8i].
REQ-008 src_last  in  NREQ  per-source flag marking the final byte of a message.
REQ-009 src_ready  out  NREQ  per-source byte accepted when src_valid and src_ready are both high.
REQ-010 grant  out  NREQ  one-hot owner of the UART; all zero when no source owns it.
REQ-011 tx_data  out  8  byte to the UART transmitter.
REQ-012 tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready.
REQ-013 tx_ready  in  1  UART transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-014 busy  out  1  high in XFER and GAP.
REQ-015 timeout_pulse  out  1  one-cycle pulse when a granted source is dropped.

Function
REQ-016 The block SHALL have three states: IDLE, XFER and GAP.
REQ-017 In IDLE, a source SHALL be requesting when its src_valid is high.
REQ-018 In IDLE, the block SHALL pick the first requesting index at or after rr_ptr (modulo NREQ), set grant to that index and enter XFER on the next cycle.
REQ-019 src_ready SHALL be zero for every source that is not granted, and zero in IDLE and GAP.
REQ-020 In XFER, src_ready[g] SHALL equal (~tx_valid | tx_ready), where g is the granted index.
REQ-021 An accepted source byte SHALL appear on tx_data with tx_valid high on the next cycle (latency 1).
REQ-022 The one-entry output register SHALL clear tx_valid on a tx_ready handshake unless a new byte is accepted in the same cycle; in that case it SHALL load the new byte.
REQ-023 Accepting a byte with src_last high SHALL move the state to GAP, clear grant and set rr_ptr to (g+1) mod NREQ.
REQ-024 The output register SHALL drain independently of state.
REQ-025 GAP SHALL last GAP_CYCLES cycles, counted from the cycle after entry, and then return to IDLE.
REQ-026 With GAP_CYCLES=0, the block SHALL go from XFER directly to IDLE.
REQ-027 GAP SHALL NOT end while tx_valid is high.
REQ-028 The stall counter SHALL reset on entry to XFER and on every accepted byte.
REQ-029 The stall counter SHALL increment only on XFER cycles where src_valid[g] is low; tx_ready back-pressure SHALL NOT count.
REQ-030 When the stall counter reaches TIMEOUT-1, the block SHALL pulse timeout_pulse for one cycle, enter GAP, clear grant and advance rr_ptr as in REQ-023.
REQ-031 When every source is requesting, service order SHALL follow rr_ptr, so each source waits at most NREQ-1 messages.
REQ-032 A source that drops src_valid mid-message SHALL keep its grant until src_last or timeout.
REQ-033 src_valid of non-granted sources SHALL have no effect outside IDLE.
REQ-034 The stall counter SHALL be 20 bits wide; the GAP counter SHALL be 16 bits wide; neither SHALL wrap.

Reset
REQ-035 While reset is high, the block SHALL hold state=IDLE, rr_ptr=0, grant=0, src_ready=0, tx_valid=0, tx_data=0, busy=0 and timeout_pulse=0, with both counters at 0.
REQ-036 Reset asserted mid-message SHALL discard the held byte and the message, with no partial tx handshake after the reset cycle.
REQ-037 Arbitration SHALL be able to start in the first cycle after reset deasserts.

Structure
REQ-038 The shared package print_arb_pkg SHALL hold the state encoding (IDLE=0, XFER=1, GAP=2) and the default parameter values.
REQ-039 The sub-module rr_pick SHALL be a combinational round-robin one-hot picker with inputs req[NREQ] and ptr, and output gnt[NREQ].
REQ-040 The FSM, the counters and the output register SHALL stay in print_arbiter.

Verification
REQ-041 Source 1 sends "Hi\r\n" with tx_ready=1 and GAP_CYCLES=16 -> tx bytes 0x48,0x69,0x0D,0x0A on consecutive cycles, each one cycle after acceptance; busy stays high for 16 cycles after the last byte; grant=3'b010 throughout the message.
REQ-042 All 3 sources request from reset with 2-byte messages -> service order 0,1,2, then 0 again; no two grant bits ever high together.
REQ-043 tx_ready held low 100 cycles mid-message, TIMEOUT=64 -> no timeout_pulse; tx_data stable; the message completes after tx_ready rises.
REQ-044 Source 0 sends 1 byte, then src_valid stays low, TIMEOUT=64 -> timeout_pulse on the 64th stall cycle; grant clears; the next request from source 1 is served.
REQ-045 Reset for 1 cycle while the 2nd of 4 bytes is held with tx_ready=0 -> the next cycle shows tx_valid=0, grant=0, rr_ptr=0; the byte is never handshaken.
REQ-046 GAP_CYCLES=0 with back-to-back messages from sources 0 and 1 -> the first byte of source 1 is accepted 2 cycles after the last byte of source 0 (1 cycle in IDLE).
